// File: rtl/tj_rx_aligner_if.sv
// rtl/tj_rx_aligner_if.sv - serial input and aligned symbol output bundle for tj_rx_aligner
interface tj_rx_aligner_if;
  logic       DATA_IN;
  logic       INVERT;
  logic       ENABLE;
  logic [9:0] DATA_OUT;
  logic       DATA_VALID;
  logic       LOCKED;
  logic [3:0] ALIGN_PHASE;
  logic [7:0] LOST_COUNT;

  modport master (
    output DATA_IN, INVERT, ENABLE,
    input  DATA_OUT, DATA_VALID, LOCKED, ALIGN_PHASE, LOST_COUNT
  );

  modport slave (
    input  DATA_IN, INVERT, ENABLE,
    output DATA_OUT, DATA_VALID, LOCKED, ALIGN_PHASE, LOST_COUNT
  );
endinterface

// File: rtl/tj_rx_aligner.sv
// rtl/tj_rx_aligner.sv - comma-based 10-bit word aligner for the TJ-Monopix2 8b10b serial stream
module tj_rx_aligner #(
  parameter int LOCK_COUNT   = 4,
  parameter int UNLOCK_COUNT = 2
) (
  input  logic           SER_CLK,
  input  logic           RESETB,
  tj_rx_aligner_if.slave rx
);

  localparam int GW = $clog2(LOCK_COUNT + 1);
  localparam int MW = $clog2(UNLOCK_COUNT + 1);
  localparam logic [GW-1:0] GOOD_ONE  = GW'(1);
  localparam logic [GW-1:0] GOOD_LAST = GW'(LOCK_COUNT - 1);
  localparam logic [MW-1:0] MISS_LAST = MW'(UNLOCK_COUNT - 1);

  typedef enum logic [1:0] {
    ST_HUNT,
    ST_VERIFY,
    ST_LOCKED
  } state_t;

  logic [9:0]    sr;
  logic [3:0]    bit_cnt;
  state_t        state_q, state_d;
  logic [3:0]    phase_q, phase_d;
  logic [GW-1:0] good_q, good_d;
  logic [MW-1:0] miss_q, miss_d;
  logic [7:0]    lost_q, lost_d;
  logic [9:0]    dout_q, dout_d;
  logic          dvalid_q, dvalid_d;

  // The comma window is the first seven received bits of the current 10-bit window
  logic comma;
  logic on_phase;
  assign comma    = (sr[9:3] == 7'b0011111) || (sr[9:3] == 7'b1100000);
  assign on_phase = (bit_cnt == phase_q);

  // Serial shift register and free-running word counter; alignment never touches bit_cnt
  always_ff @(posedge SER_CLK or negedge RESETB) begin
    if (!RESETB) begin
      sr      <= 10'd0;
      bit_cnt <= 4'd0;
    end else begin
      sr      <= {sr[8:0], rx.DATA_IN ^ rx.INVERT};
      bit_cnt <= (bit_cnt == 4'd9) ? 4'd0 : bit_cnt + 4'd1;
    end
  end

  // State and output registers
  always_ff @(posedge SER_CLK or negedge RESETB) begin
    if (!RESETB) begin
      state_q  <= ST_HUNT;
      phase_q  <= 4'd0;
      good_q   <= '0;
      miss_q   <= '0;
      lost_q   <= 8'd0;
      dout_q   <= 10'd0;
      dvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      phase_q  <= phase_d;
      good_q   <= good_d;
      miss_q   <= miss_d;
      lost_q   <= lost_d;
      dout_q   <= dout_d;
      dvalid_q <= dvalid_d;
    end
  end

  // Next-state logic: HUNT finds a comma, VERIFY confirms its phase, LOCKED emits words
  always_comb begin
    state_d  = state_q;
    phase_d  = phase_q;
    good_d   = good_q;
    miss_d   = miss_q;
    lost_d   = lost_q;
    dout_d   = dout_q;
    dvalid_d = 1'b0;

    if (!rx.ENABLE) begin
      // Disable wins over any comma; phase and loss count are kept
      state_d = ST_HUNT;
      good_d  = '0;
      miss_d  = '0;
    end else begin
      case (state_q)
        ST_HUNT: begin
          if (comma) begin
            phase_d = bit_cnt;
            good_d  = GOOD_ONE;
            miss_d  = '0;
            if (LOCK_COUNT == 1) begin
              state_d  = ST_LOCKED;
              dout_d   = sr;
              dvalid_d = 1'b1;
            end else begin
              state_d = ST_VERIFY;
            end
          end
        end
        ST_VERIFY: begin
          if (comma) begin
            if (on_phase) begin
              if (good_q == GOOD_LAST) begin
                // The comma that completes the lock is also the first output word
                state_d  = ST_LOCKED;
                miss_d   = '0;
                dout_d   = sr;
                dvalid_d = 1'b1;
              end else begin
                good_d = good_q + GOOD_ONE;
              end
            end else begin
              phase_d = bit_cnt;
              good_d  = GOOD_ONE;
            end
          end
        end
        ST_LOCKED: begin
          if (on_phase) begin
            dout_d   = sr;
            dvalid_d = 1'b1;
            if (comma) begin
              miss_d = '0;
            end
          end else if (comma) begin
            if (miss_q == MISS_LAST) begin
              state_d = ST_HUNT;
              miss_d  = '0;
              good_d  = '0;
              if (lost_q != 8'hFF) begin
                lost_d = lost_q + 8'd1;
              end
            end else begin
              miss_d = miss_q + MW'(1);
            end
          end
        end
        default: begin
          state_d = ST_HUNT;
        end
      endcase
    end
  end

  assign rx.DATA_OUT    = dout_q;
  assign rx.DATA_VALID  = dvalid_q;
  assign rx.LOCKED      = (state_q == ST_LOCKED);
  assign rx.ALIGN_PHASE = phase_q;
  assign rx.LOST_COUNT  = lost_q;

endmodule

// File: tb/tb_tj_rx_aligner.sv
// tb/tb_tj_rx_aligner.sv - scoreboard bench for tj_rx_aligner
module tb_tj_rx_aligner;

  localparam logic [9:0] K_N = 10'b0011111010;
  localparam logic [9:0] K_P = 10'b1100000101;
  localparam logic [9:0] X_W = 10'b0001111100;
  localparam logic [9:0] G1  = 10'b0001111101;
  localparam logic [9:0] G2  = 10'b0110000010;

  typedef struct {
    logic [9:0] word;
    int         edge_no;
  } exp_t;

  logic SER_CLK = 1'b0;
  logic RESETB;
  logic inv_tx;
  logic [9:0] wv;
  int n_cmp = 0;
  int n_bad = 0;
  int nbits = 0;
  int edge_cnt = 0;
  exp_t q[$];
  exp_t e;

  tj_rx_aligner_if bus ();

  tj_rx_aligner #(.LOCK_COUNT(4), .UNLOCK_COUNT(2)) dut (
    .SER_CLK (SER_CLK),
    .RESETB  (RESETB),
    .rx      (bus)
  );

  always #5 SER_CLK = ~SER_CLK;

  always @(posedge SER_CLK) edge_cnt <= (RESETB === 1'b1) ? edge_cnt + 1 : 0;

  always @(negedge SER_CLK) begin
    if (RESETB === 1'b1 && bus.DATA_VALID === 1'b1) begin
      n_cmp++;
      if (q.size() == 0) begin
        n_bad++;
        $display("FAIL strobe_unexpected: DATA_OUT=%b at edge %0d, required no strobe", bus.DATA_OUT, edge_cnt);
      end else begin
        e = q.pop_front();
        if (bus.DATA_OUT !== e.word || edge_cnt != e.edge_no) begin
          n_bad++;
          $display("FAIL strobe_word: got %b at edge %0d, required %b at edge %0d",
                   bus.DATA_OUT, edge_cnt, e.word, e.edge_no);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required normal completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  function automatic logic [9:0] kword(input int w);
    return (w % 2 == 0) ? K_N : K_P;
  endfunction

  task automatic send_bit(input logic b);
    bus.DATA_IN = b ^ inv_tx;
    @(posedge SER_CLK);
    #1;
    nbits++;
  endtask

  task automatic send_word(input logic [9:0] w, input bit expect_strobe);
    if (expect_strobe) q.push_back('{word: w, edge_no: nbits + 11});
    for (int i = 9; i >= 0; i--) send_bit(w[i]);
  endtask

  task automatic preamble(input int n);
    for (int i = 0; i < n; i++) send_bit((i % 2) == 0);
  endtask

  task automatic tail(input string name);
    repeat (3) send_bit(1'b0);
    check(name, q.size(), 0);
  endtask

  task automatic do_reset();
    RESETB = 1'b0;
    bus.DATA_IN = 1'b0;
    bus.ENABLE = 1'b1;
    repeat (2) @(posedge SER_CLK);
    q.delete();
    @(negedge SER_CLK);
    RESETB = 1'b1;
    nbits = 0;
  endtask

  initial begin
    RESETB = 1'b0;
    bus.DATA_IN = 1'b0;
    bus.INVERT = 1'b0;
    bus.ENABLE = 1'b1;
    inv_tx = 1'b0;
    wv = 10'd0;
    #12;
    check("rst_data_out", bus.DATA_OUT, 0);
    check("rst_data_valid", bus.DATA_VALID, 0);
    check("rst_locked", bus.LOCKED, 0);
    check("rst_align_phase", bus.ALIGN_PHASE, 0);
    check("rst_lost_count", bus.LOST_COUNT, 0);

    // K28.5 stream at offset 3
    do_reset();
    preamble(3);
    for (int w = 0; w < 3; w++) send_word(kword(w), 1'b0);
    send_word(kword(3), 1'b1);
    check("s1_unlocked_before_4th", bus.LOCKED, 0);
    for (int w = 4; w < 8; w++) send_word(kword(w), 1'b1);
    tail("s1_drain");
    check("s1_locked", bus.LOCKED, 1);
    check("s1_phase", bus.ALIGN_PHASE, 3);
    check("s1_lost", bus.LOST_COUNT, 0);

    // One-bit slip while locked at offset 5
    do_reset();
    preamble(5);
    for (int w = 0; w < 6; w++) send_word(kword(w), w >= 3);
    send_bit(1'b0);
    q.push_back('{word: G1, edge_no: nbits + 10});
    q.push_back('{word: G2, edge_no: nbits + 20});
    for (int w = 6; w < 9; w++) send_word(kword(w), 1'b0);
    check("s2_unlocked", bus.LOCKED, 0);
    check("s2_lost_one", bus.LOST_COUNT, 1);
    for (int w = 9; w < 11; w++) send_word(kword(w), 1'b0);
    for (int w = 11; w < 14; w++) send_word(kword(w), 1'b1);
    tail("s2_drain");
    check("s2_relocked", bus.LOCKED, 1);
    check("s2_phase", bus.ALIGN_PHASE, 6);
    check("s2_lost_kept", bus.LOST_COUNT, 1);

    // Isolated misses followed by good commas at offset 0
    do_reset();
    for (int w = 0; w < 5; w++) send_word(kword(w), w >= 3);
    send_word(X_W, 1'b1);
    send_word(K_P, 1'b1);
    send_word(X_W, 1'b1);
    send_word(K_P, 1'b1);
    send_word(K_N, 1'b1);
    tail("s3_drain");
    check("s3_locked", bus.LOCKED, 1);
    check("s3_lost", bus.LOST_COUNT, 0);
    check("s3_phase", bus.ALIGN_PHASE, 0);

    // Inverted pair, same stream as the first case
    bus.INVERT = 1'b1;
    inv_tx = 1'b1;
    do_reset();
    preamble(3);
    for (int w = 0; w < 3; w++) send_word(kword(w), 1'b0);
    send_word(kword(3), 1'b1);
    check("s4_unlocked_before_4th", bus.LOCKED, 0);
    for (int w = 4; w < 8; w++) send_word(kword(w), 1'b1);
    tail("s4_drain");
    check("s4_locked", bus.LOCKED, 1);
    check("s4_phase", bus.ALIGN_PHASE, 3);
    bus.INVERT = 1'b0;
    inv_tx = 1'b0;

    // One-cycle disable on a boundary while locked at offset 7
    do_reset();
    preamble(7);
    for (int w = 0; w < 6; w++) send_word(kword(w), (w == 3) || (w == 4));
    wv = kword(6);
    bus.ENABLE = 1'b0;
    send_bit(wv[9]);
    bus.ENABLE = 1'b1;
    check("s5_unlocked", bus.LOCKED, 0);
    check("s5_no_valid", bus.DATA_VALID, 0);
    check("s5_lost_held", bus.LOST_COUNT, 0);
    check("s5_phase_held", bus.ALIGN_PHASE, 7);
    for (int i = 8; i >= 0; i--) send_bit(wv[i]);
    for (int w = 7; w < 9; w++) send_word(kword(w), 1'b0);
    for (int w = 9; w < 11; w++) send_word(kword(w), 1'b1);
    tail("s5_drain");
    check("s5_relocked", bus.LOCKED, 1);
    check("s5_lost", bus.LOST_COUNT, 0);

    // Asynchronous reset during a strobe while locked at offset 1
    do_reset();
    preamble(1);
    for (int w = 0; w < 5; w++) send_word(kword(w), w >= 3);
    wv = kword(5);
    send_bit(wv[9]);
    check("s6_valid_before_reset", bus.DATA_VALID, 1);
    @(negedge SER_CLK);
    #1;
    RESETB = 1'b0;
    #1;
    check("s6_rst_valid", bus.DATA_VALID, 0);
    check("s6_rst_locked", bus.LOCKED, 0);
    check("s6_rst_data", bus.DATA_OUT, 0);
    check("s6_rst_phase", bus.ALIGN_PHASE, 0);
    check("s6_rst_lost", bus.LOST_COUNT, 0);
    check("s6_queue_before_reset", q.size(), 0);
    do_reset();
    preamble(1);
    for (int w = 0; w < 6; w++) send_word(kword(w), w >= 3);
    tail("s6_drain");
    check("s6_relocked", bus.LOCKED, 1);
    check("s6_phase", bus.ALIGN_PHASE, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/tj_rx_aligner.md
TJ_RX_ALIGNER -- requirements
Module: tj_rx_aligner

Serial receive aligner for the TJ-Monopix2 8b10b data output (consumes LVDS_DATA_OUT, one bit per SER_CLK).

Interface
REQ-001 SHALL have parameter LOCK_COUNT, default 4: number of consecutive same-phase commas required to lock.
REQ-002 SHALL have parameter UNLOCK_COUNT, default 2: number of consecutive wrong-phase commas that drop lock.
REQ-003 SHALL use one clock and an asynchronous, active-low reset.
REQ-004 SER_CLK  in  1  bit clock; DATA_IN is sampled on each rising edge.
REQ-005 RESETB  in  1  asynchronous active-low reset.
REQ-006 DATA_IN  in  1  serial 8b10b stream; bit "a" is transmitted first.
REQ-007 INVERT  in  1  1 = complement DATA_IN before the shift register (LVDS pair swap).
REQ-008 ENABLE  in  1  0 = hold the aligner in HUNT.
REQ-009 DATA_OUT  out  10  aligned symbol; the first-received bit is in [9].
REQ-010 DATA_VALID  out  1  one-cycle strobe that qualifies DATA_OUT.
REQ-011 LOCKED  out  1  high while the state is LOCKED.
REQ-012 ALIGN_PHASE  out  4  stored word-boundary phase, range 0..9.
REQ-013 LOST_COUNT  out  8  number of lock losses, saturating.

Function
REQ-014 The shift register SHALL update on every edge as sr <= {sr[8:0], DATA_IN^INVERT}.
REQ-015 The bit counter bit_cnt SHALL be free-running 0..9 and wrap from 9 to 0; it is never reset by alignment.
REQ-016 A comma SHALL be detected, combinationally from the registered sr, when sr[9:3] equals 0011111 or 1100000; the comma phase is the current bit_cnt.
REQ-017 The FSM SHALL have three states: HUNT, VERIFY and LOCKED. The reset state is HUNT.
REQ-018 HUNT transitions:
- on a comma, store phase <= bit_cnt, set good_cnt <= 1 and go to VERIFY;
- if LOCK_COUNT==1, go directly to LOCKED.
REQ-019 VERIFY transitions:
- comma with bit_cnt==phase: increment good_cnt; on reaching LOCK_COUNT, go to LOCKED;
- comma with bit_cnt!=phase: store the new phase, set good_cnt <= 1 and stay in VERIFY.
REQ-020 LOCKED transitions:
- comma with bit_cnt==phase: clear miss_cnt;
- comma with bit_cnt!=phase: increment miss_cnt; on reaching UNLOCK_COUNT, go to HUNT and increment LOST_COUNT, which saturates at 255.
REQ-021 In LOCKED, when bit_cnt==phase, the block SHALL register DATA_OUT <= sr and assert DATA_VALID for exactly the next cycle.
REQ-022 Latency and strobe rate:
- DATA_VALID asserts one cycle after the edge that sampled the last bit of a word;
- DATA_VALID asserts exactly once per 10 cycles while locked.
REQ-023 DATA_OUT SHALL hold its last value between strobes.
REQ-024 The strobe on the cycle that enters LOCKED:
- the edge that completes LOCK_COUNT also registers that comma word to DATA_OUT;
- DATA_VALID asserts on the following cycle.
REQ-025 On the cycle that leaves LOCKED, DATA_VALID SHALL NOT assert for that boundary.
REQ-026 While ENABLE=0, on every edge the state SHALL go to HUNT and good_cnt, miss_cnt and DATA_VALID SHALL clear.
REQ-027 ENABLE=0 SHALL take priority over any simultaneous comma.
REQ-028 While ENABLE=0, LOST_COUNT and ALIGN_PHASE SHALL hold their values.
REQ-029 Commas embedded in data at a non-boundary phase SHALL count only as misses; no other symbol content affects the FSM.
REQ-030 good_cnt and miss_cnt SHALL be sized for their parameter values and SHALL NOT wrap.

Reset
REQ-031 RESETB=0 SHALL immediately and asynchronously clear the following, with state set to HUNT:
- sr, bit_cnt, phase, good_cnt, miss_cnt;
- DATA_OUT, DATA_VALID, LOCKED, ALIGN_PHASE, LOST_COUNT.
REQ-032 Reset asserted mid-operation, including while locked, SHALL give all outputs 0 with no strobe glitch.
REQ-033 After RESETB release, the first sample SHALL be taken on the next rising edge.

Verification
REQ-034 Scenario: stream repeated K28.5 (0011111010, 1100000101 alternating) at arbitrary offset -> LOCKED=1 after the 4th comma; DATA_VALID every 10 cycles; DATA_OUT alternates between the two codes; ALIGN_PHASE equals the offset.
REQ-035 Scenario: while locked, insert one extra bit (slip) -> 2nd wrong-phase comma gives LOCKED=0 and LOST_COUNT=1; relock after 4 further commas with ALIGN_PHASE = old+1 mod 10.
REQ-036 Scenario: while locked, one wrong-phase comma then a correct-phase comma -> LOCKED stays 1; miss_cnt returns to 0; no strobe is lost.
REQ-037 Scenario: INVERT=1 with a complemented K28.5 stream -> same lock timing and DATA_OUT as the non-inverted case.
REQ-038 Scenario: ENABLE=0 for 1 cycle while locked -> LOCKED=0 on the next cycle; no DATA_VALID; LOST_COUNT unchanged; relock after 4 commas.
REQ-039 Scenario: RESETB=0 mid-word while locked -> all outputs 0 asynchronously; after release, lock is reacquired in 4 commas.
